bp_lce_mem_arb: RTL

- Arbitrates between several LCE-side engines (command, fill-return, init/sync sweep) for one shared cache memory packet port (tag, data or stat). One instance is used per memory.
- The cache pipeline owns the memory whenever it withholds mem_yumi_i.
- The block provides round-robin fairness between engines and multi-beat grant locking.
- A stall timeout asserts cache_lock_o, which forces the cache to stop issuing new requests so the pending LCE packet can drain.

---
 rtl/bp_me_pkg.sv | 10 +
 rtl/bp_lce_mem_arb_rr.sv | 31 +++
 rtl/bp_lce_mem_arb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bp_me_pkg.sv
// Shared types for the LCE-side memory arbiter.
package bp_me_pkg;

  // Arbiter FSM: no held grant, or grant held mid-burst on one owner.
  typedef enum logic [0:0] {
    e_arb_idle,
    e_arb_locked
  } bp_lce_mem_arb_state_e;

endpackage

// File: rtl/bp_lce_mem_arb_rr.sv
// Rotating-priority picker: first set request bit searching upward from rr_ptr_i, wrapping.
// Purely combinational; all state lives in the parent.
module bp_lce_mem_arb_rr #(
  parameter int unsigned num_req_p  = 2,
  parameter int unsigned id_width_p = 1
) (
  input  logic [num_req_p-1:0]  req_i,
  input  logic [id_width_p-1:0] rr_ptr_i,
  output logic [num_req_p-1:0]  grant_oh_o,
  output logic [id_width_p-1:0] grant_id_o
);

  logic found;

  // Walk priority offsets 0..N-1 from the pointer; the first valid requester wins.
  always_comb begin
    grant_oh_o = '0;
    grant_id_o = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      for (int unsigned j = 0; j < num_req_p; j++) begin
        if (!found && req_i[j] && (j == (32'(rr_ptr_i) + i) % num_req_p)) begin
          found         = 1'b1;
          grant_oh_o[j] = 1'b1;
          grant_id_o    = id_width_p'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bp_lce_mem_arb.sv
// Arbitrates LCE-side engines onto one shared cache memory packet port.
// Round-robin between requesters, grant locked across multi-beat bursts, and a stall
// timeout that raises cache_lock_o so the pending LCE packet can drain.
// Optional build macro BP_LCE_MEM_ARB_STATS_EN adds stall_cnt_o and grant_cnt_o.
module bp_lce_mem_arb
  import bp_me_pkg::*;
#(
  parameter int unsigned num_req_p           = 2,
  parameter int unsigned pkt_width_p         = 64,
  parameter int unsigned timeout_max_limit_p = 4,
  localparam int unsigned id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned cnt_width_lp = $clog2(timeout_max_limit_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]             req_last_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic                             mem_pkt_v_o,
  output logic [pkt_width_p-1:0]           mem_pkt_o,
  input  logic                             mem_yumi_i,
  output logic [id_width_lp-1:0]           grant_id_o,
  output logic                             cache_lock_o,
`ifdef BP_LCE_MEM_ARB_STATS_EN
  output logic [31:0]                      stall_cnt_o,
  output logic [num_req_p*16-1:0]          grant_cnt_o,
`endif
  output logic                             busy_o
);

  localparam logic [cnt_width_lp-1:0] CntMax = cnt_width_lp'(timeout_max_limit_p);
  localparam logic [id_width_lp-1:0]  IdMax  = id_width_lp'(num_req_p - 1);

  bp_lce_mem_arb_state_e   state_q;
  logic [id_width_lp-1:0]  owner_q;
  logic [id_width_lp-1:0]  rr_ptr_q;
  logic [cnt_width_lp-1:0] count_q;
  logic [cnt_width_lp-1:0] count_d;

  logic [num_req_p-1:0]    rr_grant_oh;
  logic [id_width_lp-1:0]  rr_grant_id;

  logic [id_width_lp-1:0]  grantee;
  logic                    grantee_v;
  logic                    grantee_last;
  logic [pkt_width_p-1:0]  grantee_pkt;
  logic                    accept;
  logic                    stall;
  logic [id_width_lp-1:0]  rr_ptr_next;

  bp_lce_mem_arb_rr #(
    .num_req_p  (num_req_p),
    .id_width_p (id_width_lp)
  ) u_rr (
    .req_i      (req_v_i),
    .rr_ptr_i   (rr_ptr_q),
    .grant_oh_o (rr_grant_oh),
    .grant_id_o (rr_grant_id)
  );

  // Select the grantee (held owner or fresh winner) and mux its valid, last and packet.
  always_comb begin
    grantee      = (state_q == e_arb_locked) ? owner_q : rr_grant_id;
    grantee_v    = 1'b0;
    grantee_last = 1'b0;
    grantee_pkt  = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grantee == id_width_lp'(i)) begin
        grantee_v    = req_v_i[i];
        grantee_last = req_last_i[i];
        grantee_pkt  = req_pkt_i[i*pkt_width_p +: pkt_width_p];
      end
    end
    // In idle the picker finds a winner iff any request is valid.
    if (state_q == e_arb_idle) begin
      grantee_v = |rr_grant_oh;
    end
  end

  // Outputs are forced to zero while reset is held, including the combinational paths.
  always_comb begin
    mem_pkt_v_o  = reset_n_i & grantee_v;
    mem_pkt_o    = reset_n_i ? grantee_pkt : '0;
    grant_id_o   = reset_n_i ? grantee : '0;
    accept       = mem_pkt_v_o & mem_yumi_i;
    cache_lock_o = reset_n_i & (count_q == CntMax);
    busy_o       = reset_n_i & (state_q == e_arb_locked);
    req_yumi_o   = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      req_yumi_o[i] = accept & (grantee == id_width_lp'(i));
    end
  end

  // Next rr pointer is one past the grantee of a completed burst, wrapping at num_req_p.
  always_comb begin
    rr_ptr_next = (grantee == IdMax) ? '0 : grantee + 1'b1;
  end

  // Saturating stall count; any non-stalled cycle clears it.
  always_comb begin
    stall   = mem_pkt_v_o & ~mem_yumi_i;
    count_d = '0;
    if (stall) begin
      count_d = (count_q == CntMax) ? count_q : count_q + 1'b1;
    end
  end

  // Grant FSM: lock on a non-last accept, release and rotate priority on a last accept.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_arb_idle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      if (grantee_last) begin
        state_q  <= e_arb_idle;
        rr_ptr_q <= rr_ptr_next;
      end else begin
        state_q <= e_arb_locked;
        owner_q <= grantee;
      end
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef BP_LCE_MEM_ARB_STATS_EN
  logic [31:0]                 stall_cnt_q;
  logic [num_req_p-1:0][15:0]  grant_cnt_q;

  // Lock-cycle count saturates; per-requester completed-burst counts wrap.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      if (cache_lock_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (accept && grantee_last && (grantee == id_width_lp'(i))) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule
